bcd_tick_counter: RTL and testbench

- Multi-digit BCD up/down counter with a built-in prescaler.
- Drives the 4-bit digit inputs of the downstream per-digit seven-segment decoders; each 4-bit output nibble holds one BCD digit, 0-9 only.
- Sits directly upstream of the display decoders. A wrap pulse is available for cascading or for control logic.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_tick_counter.sv | 81 ++++++++
 tb/tb_bcd_tick_counter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and the saturation helper used by the tick counter.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [BCD_W-1:0] bcd_t;

    function automatic bcd_t bcd_sat(input logic [BCD_W-1:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit cell; chained through cin/cout as a ripple carry/borrow.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_t digit,
    input  logic up,
    input  logic cin,
    output bcd_t next_digit,
    output logic cout
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                // >= so a corrupted nibble still recovers into the legal range
                if (digit >= BCD_MAX) begin
                    next_digit = BCD_MIN;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_MIN) begin
                    next_digit = BCD_MAX;
                    cout       = 1'b1;
                end else begin
                    next_digit = bcd_sat(digit) - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler.
// Define BCD_TICK_COUNTER_LOAD_EN to add the parallel load ports (load_in, load_val_in).
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_in,
    input  logic                  up_in,
    input  logic                  clear_in,
`ifdef BCD_TICK_COUNTER_LOAD_EN
    input  logic                  load_in,
    input  logic [4*DIGITS-1:0]   load_val_in,
`endif
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  wrap_out
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]       presc;
    logic                step;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] digits_nxt;
    logic                load_req;
    logic [4*DIGITS-1:0] load_sat;

`ifdef BCD_TICK_COUNTER_LOAD_EN
    assign load_req = load_in;
    for (genvar k = 0; k < DIGITS; k++) begin : g_load_sat
        assign load_sat[4*k +: 4] = bcd_sat(load_val_in[4*k +: 4]);
    end
`else
    assign load_req = 1'b0;
    assign load_sat = '0;
`endif

    assign step     = en_in && (presc == PRE_LAST);
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .digit      (digits_out[4*k +: 4]),
            .up         (up_in),
            .cin        (carry[k]),
            .next_digit (digits_nxt[4*k +: 4]),
            .cout       (carry[k+1])
        );
    end

    // carry out of the top digit is exactly the full-range wrap condition
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            presc      <= '0;
            digits_out <= '0;
            wrap_out   <= 1'b0;
        end else if (clear_in) begin
            presc      <= '0;
            digits_out <= '0;
            wrap_out   <= 1'b0;
        end else if (load_req) begin
            presc      <= '0;
            digits_out <= load_sat;
            wrap_out   <= 1'b0;
        end else begin
            wrap_out <= 1'b0;
            if (step) begin
                presc      <= '0;
                digits_out <= digits_nxt;
                wrap_out   <= carry[DIGITS];
            end else if (en_in) begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench: two counters (TICK_DIV=4 and TICK_DIV=1) against an integer-valued reference model.
module tb_bcd_tick_counter;

    localparam int ND   = 2;
    localparam int MAXV = 99;
    localparam int TD0  = 4;
    localparam int TD1  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_s  [2];
    logic       up_s  [2];
    logic       clr_s [2];
    logic [7:0] dig   [2];
    logic       wr    [2];
`ifdef BCD_TICK_COUNTER_LOAD_EN
    logic       ld_s  [2];
    logic [7:0] ld_val[2];
`endif

    int m_val [2];
    int m_pre [2];
    bit m_wrap[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_tick_counter #(.DIGITS(ND), .TICK_DIV(TD0)) dut4 (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .en_in      (en_s[0]),
        .up_in      (up_s[0]),
        .clear_in   (clr_s[0]),
`ifdef BCD_TICK_COUNTER_LOAD_EN
        .load_in    (ld_s[0]),
        .load_val_in(ld_val[0]),
`endif
        .digits_out (dig[0]),
        .wrap_out   (wr[0])
    );

    bcd_tick_counter #(.DIGITS(ND), .TICK_DIV(TD1)) dut1 (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .en_in      (en_s[1]),
        .up_in      (up_s[1]),
        .clear_in   (clr_s[1]),
`ifdef BCD_TICK_COUNTER_LOAD_EN
        .load_in    (ld_s[1]),
        .load_val_in(ld_val[1]),
`endif
        .digits_out (dig[1]),
        .wrap_out   (wr[1])
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        int         x;
        r = '0;
        x = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: counter value as a plain integer in 0..MAXV, prescaler as a cycle count
    task automatic model_cycle(input int i, input int td);
        if (clr_s[i]) begin
            m_val[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
        end
`ifdef BCD_TICK_COUNTER_LOAD_EN
        else if (ld_s[i]) begin
            int hi, lo;
            hi = (ld_val[i][7:4] > 9) ? 9 : int'(ld_val[i][7:4]);
            lo = (ld_val[i][3:0] > 9) ? 9 : int'(ld_val[i][3:0]);
            m_val[i] = hi * 10 + lo; m_pre[i] = 0; m_wrap[i] = 0;
        end
`endif
        else begin
            m_wrap[i] = 0;
            if (en_s[i]) begin
                if (m_pre[i] == td - 1) begin
                    m_pre[i] = 0;
                    if (up_s[i]) begin
                        m_wrap[i] = (m_val[i] == MAXV);
                        m_val[i]  = (m_val[i] + 1) % (MAXV + 1);
                    end else begin
                        m_wrap[i] = (m_val[i] == 0);
                        m_val[i]  = (m_val[i] + MAXV) % (MAXV + 1);
                    end
                end else begin
                    m_pre[i]++;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_cycle(0, TD0);
        model_cycle(1, TD1);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            en_s[i] = 1'b0; up_s[i] = 1'b1; clr_s[i] = 1'b0;
`ifdef BCD_TICK_COUNTER_LOAD_EN
            ld_s[i] = 1'b0; ld_val[i] = '0;
`endif
        end
    endtask

    task automatic clear_both();
        idle_inputs();
        clr_s[0] = 1'b1; clr_s[1] = 1'b1;
        tick();
        clr_s[0] = 1'b0; clr_s[1] = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dig[i] !== 8'h00 || wr[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d] digits=%h wrap=%b expected 00/0", i, dig[i], wr[i]);
            end
        end
        en_s[0] = 1'b1; en_s[1] = 1'b1;
        for (int c = 0; c < 150; c++) begin
            en_s[1] = (c < 37);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dig[i] !== 8'h37) begin
                n_fail++;
                $display("FAIL reach_37[%0d] digits=%h expected 37", i, dig[i]);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dig[i] !== 8'h00 || wr[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset[%0d] digits=%h wrap=%b expected 00/0", i, dig[i], wr[i]);
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        en_s[1] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (dig[0] !== to_bcd(m_val[0]) || dig[0] !== ((c == 4) ? 8'h01 : 8'h00)) begin
                n_fail++;
                $display("FAIL post_reset_step c=%0d digits=%h model=%h", c, dig[0], to_bcd(m_val[0]));
            end
        end
    endtask

    task automatic test_up_wrap();
        int wraps;
        bit seen_09_10;
        logic [7:0] prev;
        clear_both();
        en_s[0] = 1'b1; up_s[0] = 1'b1;
        wraps = 0; seen_09_10 = 0; prev = dig[0];
        for (int c = 0; c < 400; c++) begin
            tick();
            n_tests++;
            if (dig[0] !== to_bcd(m_val[0]) || wr[0] !== m_wrap[0]) begin
                n_fail++;
                $display("FAIL up_seq c=%0d digits=%h wrap=%b model=%h/%0b", c, dig[0], wr[0], to_bcd(m_val[0]), m_wrap[0]);
            end
            if (wr[0] === 1'b1) wraps++;
            if (prev == 8'h09 && dig[0] == 8'h10) seen_09_10 = 1;
            prev = dig[0];
        end
        n_tests++;
        if (wraps != 1 || dig[0] !== 8'h00 || !seen_09_10) begin
            n_fail++;
            $display("FAIL up_wrap wraps=%0d digits=%h saw09to10=%0b expected 1/00/1", wraps, dig[0], seen_09_10);
        end
        tick();
        n_tests++;
        if (wr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_one_cycle wrap=%b expected 0", wr[0]);
        end
    endtask

    task automatic test_down_borrow();
        clear_both();
        en_s[1] = 1'b1; up_s[1] = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (dig[1] !== 8'h10) begin
            n_fail++;
            $display("FAIL down_start digits=%h expected 10", dig[1]);
        end
        up_s[1] = 1'b0;
        tick();
        n_tests++;
        if (dig[1] !== 8'h09 || wr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL down_borrow digits=%h wrap=%b expected 09/0", dig[1], wr[1]);
        end
        repeat (9) tick();
        n_tests++;
        if (dig[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL down_zero digits=%h expected 00", dig[1]);
        end
        tick();
        n_tests++;
        if (dig[1] !== 8'h99 || wr[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap digits=%h wrap=%b expected 99/1", dig[1], wr[1]);
        end
        tick();
        n_tests++;
        if (dig[1] !== 8'h98 || wr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL down_after_wrap digits=%h wrap=%b expected 98/0", dig[1], wr[1]);
        end
    endtask

    task automatic test_enable_gating();
        clear_both();
        en_s[0] = 1'b1; up_s[0] = 1'b1;
        repeat (2) tick();
        en_s[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            up_s[0] = c[0];
            tick();
            n_tests++;
            if (dig[0] !== 8'h00 || wr[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL gated_hold c=%0d digits=%h wrap=%b expected 00/0", c, dig[0], wr[0]);
            end
        end
        en_s[0] = 1'b1; up_s[0] = 1'b1;
        tick();
        n_tests++;
        if (dig[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL gated_early digits=%h expected 00", dig[0]);
        end
        tick();
        n_tests++;
        if (dig[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL gated_resume digits=%h expected 01", dig[0]);
        end
    endtask

    task automatic test_clear_on_wrap();
        clear_both();
        en_s[0] = 1'b1; up_s[0] = 1'b1;
        repeat (399) tick();
        n_tests++;
        if (dig[0] !== 8'h99) begin
            n_fail++;
            $display("FAIL pre_clear digits=%h expected 99", dig[0]);
        end
        clr_s[0] = 1'b1;
        tick();
        clr_s[0] = 1'b0;
        n_tests++;
        if (dig[0] !== 8'h00 || wr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_on_wrap digits=%h wrap=%b expected 00/0", dig[0], wr[0]);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (dig[0] !== ((c == 4) ? 8'h01 : 8'h00) || wr[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_restart c=%0d digits=%h wrap=%b", c, dig[0], wr[0]);
            end
        end
    endtask

`ifdef BCD_TICK_COUNTER_LOAD_EN
    task automatic test_load();
        clear_both();
        ld_s[0] = 1'b1; ld_val[0] = 8'h5C;
        tick();
        ld_s[0] = 1'b0;
        n_tests++;
        if (dig[0] !== 8'h59 || wr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_sat digits=%h wrap=%b expected 59/0", dig[0], wr[0]);
        end
        ld_s[1] = 1'b1; ld_val[1] = 8'h99;
        tick();
        en_s[1] = 1'b1; up_s[1] = 1'b1; ld_val[1] = 8'h99;
        tick();
        ld_s[1] = 1'b0;
        n_tests++;
        if (dig[1] !== 8'h99 || wr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_step digits=%h wrap=%b expected 99/0", dig[1], wr[1]);
        end
        ld_s[0] = 1'b1; clr_s[0] = 1'b1; ld_val[0] = 8'h42;
        tick();
        ld_s[0] = 1'b0; clr_s[0] = 1'b0;
        n_tests++;
        if (dig[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL load_vs_clear digits=%h expected 00", dig[0]);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                en_s[i]  = ($urandom_range(0, 9) < 7);
                up_s[i]  = ($urandom_range(0, 9) < 6);
                clr_s[i] = ($urandom_range(0, 99) < 2);
`ifdef BCD_TICK_COUNTER_LOAD_EN
                ld_s[i]   = ($urandom_range(0, 99) < 3);
                ld_val[i] = 8'($urandom);
`endif
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (dig[i] !== to_bcd(m_val[i]) || wr[i] !== m_wrap[i]
                    || dig[i][3:0] > 4'd9 || dig[i][7:4] > 4'd9) begin
                    n_fail++;
                    $display("FAIL random[%0d] c=%0d digits=%h wrap=%b model=%h/%0b", i, c, dig[i], wr[i], to_bcd(m_val[i]), m_wrap[i]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_enable_gating();
        test_clear_on_wrap();
`ifdef BCD_TICK_COUNTER_LOAD_EN
        test_load();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
